c64_bus_arbiter: RTL and testbench
==================================

# c64_bus_arbiter

Shares the single 64 KiB system RAM port between the 6502 core and a video/DMA fetch requester. Sits between `_6502` (di/do/ab/we) and the RAM model. Stalls the CPU with `cpu_rdy` and honours a fixed BA-style hand-over delay before taking the bus, so in-flight CPU write cycles complete. Also returns fetched data to the requester and counts stall cycles.

## Interface
- BA_DELAY, 3, cycles `cpu_rdy` is low with the CPU still owning the bus before the DMA takes it (legal 1..7)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_ab  in  16  CPU address
- cpu_do  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_di  out  8  read data to CPU
- cpu_rdy  out  1  high = CPU may advance; low = stalled
- vid_req  in  1  level request for DMA bus ownership; held high for the whole burst
- vid_ab  in  16  DMA read address
- vid_di  out  8  DMA read data, valid when `vid_ack` high
- vid_ack  out  1  high in each cycle a DMA read is performed on RAM
- mem_ab  out  16  RAM address
- mem_do  out  8  RAM write data
- mem_we  out  1  RAM write enable (RAM writes on rising edge when high)
- mem_di  in  8  RAM read data, combinational from `mem_ab`
- stall_cnt  out  16  count of cycles with `cpu_rdy` low

## Operation
- States: CPU, WAIT, DMA. Reset state CPU.
- CPU: mem_ab=cpu_ab, mem_do=cpu_do, mem_we=cpu_we, cpu_rdy=1, vid_ack=0, cpu_di=mem_di. `vid_req` sampled high → WAIT, counter loaded with BA_DELAY-1.
- WAIT: bus still CPU's (same muxing as CPU, including writes); cpu_rdy=0; cpu_di=mem_di. Counter decrements each cycle; at counter==0 with vid_req high → DMA. vid_req low in any WAIT cycle → CPU (abort, no ack ever issued).
- DMA: mem_ab=vid_ab, mem_we=0, mem_do=cpu_do (don't care), vid_ack=1, vid_di=mem_di, cpu_rdy=0. vid_req sampled low → CPU; else stay.
- cpu_di in DMA: holds the registered value of mem_di from the last non-DMA cycle (`cpu_di_hold` captured every CPU/WAIT cycle); never shows DMA data.
- vid_di outside DMA: holds last DMA read value; reset value 8'h00.
- stall_cnt: +1 on every rising edge where cpu_rdy was low; 16-bit wrap 16'hFFFF→16'h0000; never cleared except by reset.
- mem_we is never high in DMA state (DMA is read-only).

## Timing
- Reset (async, immediate): state CPU, cpu_rdy=1, vid_ack=0, mem_we=cpu_we passthrough, cpu_di_hold=8'h00, vid_di=8'h00, stall_cnt=0, counter=0. Reset mid-WAIT/DMA aborts instantly; bus returns to CPU in same cycle.
- vid_req high before edge k → cycles k..k+BA_DELAY-1 are WAIT (rdy low, CPU owns bus); edge k+BA_DELAY → DMA; first vid_ack in cycle k+BA_DELAY.
- Each DMA cycle = one read; data valid combinationally in that cycle.
- vid_req low before edge m while in DMA → CPU from edge m; cpu_rdy=1 and vid_ack=0 in that cycle. Minimum DMA burst: 1 cycle.
- vid_req re-asserted in the first CPU cycle after a burst → full BA_DELAY again (no shortcut); CPU gets ≥1 cycle between bursts.
- Simultaneous vid_req drop and WAIT expiry (counter==0, vid_req low) → CPU, not DMA.
- All outputs except stall_cnt, vid_di, cpu_di_hold are combinational from state and inputs.

## Test plan
- Reset then idle: CPU runs LDX #5 / LDY #$0B / LDA $05FE,X / STA $05FE,Y with vid_req=0 → RAM[$0609]=22, cpu_rdy constantly 1, stall_cnt=0.
- Single DMA read, BA_DELAY=3: RAM[$0400]=8'h5A, vid_ab=$0400, vid_req high for 4 cycles → rdy low exactly 3+1=4... cycles from assert edge until release; vid_ack high 1 cycle with vid_di=8'h5A; stall_cnt=4.
- CPU write during WAIT: STA issued in WAIT cycle → write lands in RAM (mem_we=1 while rdy=0); no RAM write during DMA cycles.
- Abort: vid_req high 2 cycles then low (BA_DELAY=3) → never enters DMA, vid_ack never high, cpu_rdy back high, stall_cnt=2.
- Reset mid-DMA: assert reset during 3rd DMA cycle → same-cycle cpu_rdy=1, vid_ack=0, stall_cnt=0; after release CPU re-fetches from reset vector path.
- Wrap: preload run of 65536 stall cycles (long burst) → stall_cnt returns to 0; cpu_di unchanged throughout DMA, equals last CPU-cycle read.

Source files
------------

// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter
// Shares the single 64 KiB RAM port between the 6502 core and the video/DMA
// fetch requester. The CPU is stalled through cpu_rdy and keeps the bus for
// BA_DELAY cycles before the DMA side takes over, so an in-flight CPU write
// still lands. DMA bursts are read-only; stalled cycles are counted.

module c64_bus_arbiter #(
    parameter int unsigned BA_DELAY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        vid_req,
    input  logic [15:0] vid_ab,
    output logic [7:0]  vid_di,
    output logic        vid_ack,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    // Counter start value: BA_DELAY cycles of WAIT means BA_DELAY-1 down to 0.
    localparam logic [2:0] WAIT_LOAD = 3'(BA_DELAY - 1);

    state_t      state_r;
    logic [2:0]  count_r;
    logic [7:0]  cpu_di_hold_r;
    logic [7:0]  vid_di_r;
    logic [15:0] stall_cnt_r;

    // Bus ownership state machine with the BA-style hand-over countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_CPU;
            count_r <= 3'd0;
        end else begin
            case (state_r)
                ST_CPU: begin
                    if (vid_req) begin
                        state_r <= ST_WAIT;
                        count_r <= WAIT_LOAD;
                    end else begin
                        state_r <= ST_CPU;
                    end
                end
                ST_WAIT: begin
                    // A dropped request wins over an expiring countdown.
                    if (!vid_req) begin
                        state_r <= ST_CPU;
                        count_r <= 3'd0;
                    end else if (count_r == 3'd0) begin
                        state_r <= ST_DMA;
                    end else begin
                        count_r <= count_r - 3'd1;
                    end
                end
                ST_DMA: begin
                    if (!vid_req) begin
                        state_r <= ST_CPU;
                    end else begin
                        state_r <= ST_DMA;
                    end
                end
                default: begin
                    state_r <= ST_CPU;
                    count_r <= 3'd0;
                end
            endcase
        end
    end

    // Data holding registers: last CPU-side read and last DMA read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_di_hold_r <= 8'h00;
            vid_di_r      <= 8'h00;
        end else if (state_r == ST_DMA) begin
            vid_di_r      <= mem_di;
        end else begin
            cpu_di_hold_r <= mem_di;
        end
    end

    // Stall counter: one tick per cycle the CPU was held, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (state_r != ST_CPU) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // RAM port muxing and handshake outputs, derived from the current owner.
    always_comb begin
        mem_ab  = cpu_ab;
        mem_do  = cpu_do;
        mem_we  = cpu_we;
        cpu_rdy = 1'b1;
        vid_ack = 1'b0;
        cpu_di  = mem_di;
        vid_di  = vid_di_r;
        case (state_r)
            ST_CPU: begin
                cpu_rdy = 1'b1;
            end
            ST_WAIT: begin
                cpu_rdy = 1'b0;
            end
            ST_DMA: begin
                mem_ab  = vid_ab;
                mem_we  = 1'b0;
                cpu_rdy = 1'b0;
                vid_ack = 1'b1;
                cpu_di  = cpu_di_hold_r;
                vid_di  = mem_di;
            end
            default: begin
                cpu_rdy = 1'b1;
            end
        endcase
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Self-checking bench for c64_bus_arbiter. The bench owns the RAM and acts as
// the CPU bus master. Its model tracks only how many consecutive edges the
// request has been seen high since the CPU last owned the bus.

module tb_c64_bus_arbiter;

    localparam int BA = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        vid_req;
    logic [15:0] vid_ab;
    logic [7:0]  vid_di;
    logic        vid_ack;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;
    logic [15:0] stall_cnt;

    logic [7:0]  ram [0:65535];

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_run = 0;
    logic [15:0] m_stall = 16'h0000;
    logic [7:0]  m_hold = 8'h00;
    logic [7:0]  m_vid = 8'h00;
    logic        e_dma;

    int ack_seen = 0;
    int low_seen = 0;
    int a0;
    int l0;

    c64_bus_arbiter #(.BA_DELAY(BA)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_we    (cpu_we),
        .cpu_di    (cpu_di),
        .cpu_rdy   (cpu_rdy),
        .vid_req   (vid_req),
        .vid_ab    (vid_ab),
        .vid_di    (vid_di),
        .vid_ack   (vid_ack),
        .mem_ab    (mem_ab),
        .mem_do    (mem_do),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // RAM: combinational read, write on rising edge
    assign mem_di = ram[mem_ab];
    always @(posedge clk) begin
        if (mem_we) ram[mem_ab] <= mem_do;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Model: run = 0 -> CPU owns bus, 1..BA -> hand-over, > BA -> DMA
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run   <= 0;
            m_stall <= 16'h0000;
            m_hold  <= 8'h00;
            m_vid   <= 8'h00;
        end else begin
            if (m_run > 0) m_stall <= m_stall + 16'h0001;
            if (m_run > BA) m_vid <= ram[vid_ab];
            else            m_hold <= ram[cpu_ab];
            m_run <= vid_req ? m_run + 1 : 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        e_dma = (m_run > BA);
        chk("cpu_rdy",   16'(cpu_rdy), 16'(m_run == 0));
        chk("vid_ack",   16'(vid_ack), 16'(e_dma));
        chk("mem_ab",    mem_ab, e_dma ? vid_ab : cpu_ab);
        chk("mem_we",    16'(mem_we), 16'(e_dma ? 1'b0 : cpu_we));
        chk("mem_do",    16'(mem_do), 16'(cpu_do));
        chk("cpu_di",    16'(cpu_di), 16'(e_dma ? m_hold : ram[cpu_ab]));
        chk("vid_di",    16'(vid_di), 16'(e_dma ? ram[vid_ab] : m_vid));
        chk("stall_cnt", stall_cnt, m_stall);
        if (vid_ack)  ack_seen++;
        if (!cpu_rdy) low_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_cycle(input logic [15:0] ab, input logic [7:0] d, input logic we);
        cpu_ab = ab;
        cpu_do = d;
        cpu_we = we;
        step();
    endtask

    initial begin
        cpu_ab  = 16'h0000;
        cpu_do  = 8'h00;
        cpu_we  = 1'b0;
        vid_req = 1'b0;
        vid_ab  = 16'h0000;
        reset   = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_rdy",    16'(cpu_rdy), 16'h0001);
        chk("rst_ack",    16'(vid_ack), 16'h0000);
        chk("rst_stall",  stall_cnt, 16'h0000);
        chk("rst_vid_di", 16'(vid_di), 16'h0000);
        #3 reset = 1'b0;
        step();

        // Preload RAM through CPU writes
        cpu_cycle(16'h0603, 8'd22,  1'b1);
        cpu_cycle(16'h0400, 8'h5A,  1'b1);
        cpu_cycle(16'h0701, 8'h3C,  1'b1);
        cpu_cycle(16'hFFFC, 8'h34,  1'b1);
        cpu_cycle(16'h1234, 8'h77,  1'b1);

        // Idle program: LDA $05FE,X (X=5) reads $0603; STA $05FE,Y (Y=$0B) writes $0609
        cpu_ab = 16'h0603; cpu_we = 1'b0;
        #2 chk("lda_data", 16'(cpu_di), 16'd22);
        step();
        cpu_cycle(16'h0609, 8'd22, 1'b1);
        cpu_ab = 16'h0609; cpu_we = 1'b0;
        #2;
        chk("sta_landed", 16'(ram[16'h0609]), 16'd22);
        chk("idle_stall", stall_cnt, 16'h0000);
        step();

        // Single DMA read: request held 4 edges
        vid_ab = 16'h0400; cpu_ab = 16'h0000;
        a0 = ack_seen; l0 = low_seen;
        vid_req = 1'b1;
        repeat (4) step();
        vid_req = 1'b0;
        repeat (2) step();
        chk("dma1_acks",   16'(ack_seen - a0), 16'd1);
        chk("dma1_lowcyc", 16'(low_seen - l0), 16'd4);
        chk("dma1_vid_di", 16'(vid_di), 16'h005A);
        chk("dma1_stall",  stall_cnt, 16'd4);

        // CPU write during hand-over; CPU keeps write enable high into DMA
        cpu_ab = 16'h0700; cpu_we = 1'b0; vid_ab = 16'h0701;
        vid_req = 1'b1;
        step();
        cpu_do = 8'hA5; cpu_we = 1'b1;
        #2 chk("wait_rdy_we", 16'({cpu_rdy, mem_we}), 16'h0001);
        step();
        repeat (3) step();
        vid_req = 1'b0;
        step();
        cpu_we = 1'b0;
        step();
        chk("wait_write",   16'(ram[16'h0700]), 16'h00A5);
        chk("dma_no_write", 16'(ram[16'h0701]), 16'h003C);
        chk("wait_vid_di",  16'(vid_di), 16'h003C);
        chk("wait_stall",   stall_cnt, 16'd9);

        // Abort after 2 hand-over cycles
        a0 = ack_seen;
        vid_req = 1'b1;
        repeat (2) step();
        vid_req = 1'b0;
        repeat (2) step();
        chk("abort_acks",  16'(ack_seen - a0), 16'd0);
        chk("abort_rdy",   16'(cpu_rdy), 16'h0001);
        chk("abort_stall", stall_cnt, 16'd11);

        // Request drops exactly as the hand-over expires
        a0 = ack_seen;
        vid_req = 1'b1;
        repeat (3) step();
        vid_req = 1'b0;
        repeat (2) step();
        chk("expiry_acks",  16'(ack_seen - a0), 16'd0);
        chk("expiry_stall", stall_cnt, 16'd14);

        // Back-to-back bursts: one idle CPU cycle, full delay again
        a0 = ack_seen;
        vid_req = 1'b1;
        repeat (4) step();
        vid_req = 1'b0;
        step();
        vid_req = 1'b1;
        repeat (4) step();
        vid_req = 1'b0;
        repeat (2) step();
        chk("b2b_acks",  16'(ack_seen - a0), 16'd2);
        chk("b2b_stall", stall_cnt, 16'd22);

        // Reset during the third DMA cycle
        vid_ab = 16'h0400;
        vid_req = 1'b1;
        repeat (6) step();
        chk("pre_rst_ack", 16'(vid_ack), 16'h0001);
        reset = 1'b1;
        #1;
        chk("midrst_rdy",   16'(cpu_rdy), 16'h0001);
        chk("midrst_ack",   16'(vid_ack), 16'h0000);
        chk("midrst_stall", stall_cnt, 16'h0000);
        vid_req = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        step();
        cpu_ab = 16'hFFFC; cpu_we = 1'b0;
        #2 chk("rst_vector", 16'(cpu_di), 16'h0034);
        step();

        // Stall counter wrap over a 65536-cycle burst; CPU data frozen in DMA
        cpu_ab = 16'h1234; cpu_we = 1'b0;
        step();
        a0 = ack_seen;
        vid_ab = 16'h0400;
        vid_req = 1'b1;
        repeat (100) step();
        cpu_ab = 16'h0603;
        #2 chk("dma_cpu_di_frozen", 16'(cpu_di), 16'h0077);
        repeat (65436) step();
        vid_req = 1'b0;
        step();
        #2;
        chk("wrap_stall", stall_cnt, 16'h0000);
        chk("wrap_acks",  16'(ack_seen - a0), 16'(65533));
        chk("wrap_rdy",   16'(cpu_rdy), 16'h0001);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
